// File: rtl/rf_wr_queue.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wr_queue
//  Purpose  : Write-side requester for the triple-ported register file.
//             Collects up to two results per cycle (load, then ALU), keeps
//             them in an in-order circular queue and retires one entry per
//             cycle onto the register file's single write port. Optionally
//             forwards still-queued values to two decode read lookups.
//  Ports    : clk, rst               - clock, async active-high reset
//             ld_we/ld_addr/ld_data  - load result (older of the pair)
//             alu_we/alu_addr/alu_data - ALU result (younger of the pair)
//             dst_addr/dst/we        - register file write port
//             rd0_addr/rd1_addr      - decode read addresses for lookup
//             hit0/hit1, fwd0/fwd1   - forwarding match flags and data
//             full/empty/ovf         - stall, idle and sticky-overflow flags
//  Config   : RF_WQ_FWD_EN - when defined, forwarding comparators are built;
//             otherwise hit*/fwd* are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wr_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 4,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          alu_we,
   input  logic [AW-1:0] alu_addr,
   input  logic [DW-1:0] alu_data,
   output logic [AW-1:0] dst_addr,
   output logic [DW-1:0] dst,
   output logic          we,
   input  logic [AW-1:0] rd0_addr,
   input  logic [AW-1:0] rd1_addr,
   output logic          hit0,
   output logic          hit1,
   output logic [DW-1:0] fwd0,
   output logic [DW-1:0] fwd1,
   output logic          full,
   output logic          empty,
   output logic          ovf
);

   localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CW = c_PW + 1;

   // Entry storage carries no reset: validity is defined by count/pointers.
   logic [AW-1:0]   addr_q [DEPTH];
   logic [DW-1:0]   data_q [DEPTH];

   logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_CW-1:0] count_q,  count_d;
   logic            ovf_q,    ovf_d;

   logic            pop;
   logic            ld_v, alu_v;
   logic            ld_acc, alu_acc;
   logic [c_CW-1:0] space;
   logic [c_PW-1:0] alu_idx;

   // R0 is hardwired, so writes to it never occupy an entry.
   assign ld_v  = ld_we  && (ld_addr  != '0);
   assign alu_v = alu_we && (alu_addr != '0);

   // The head leaves on every edge while the queue is non-empty.
   assign pop = (count_q != '0);

   // Free slots at this edge, counting the slot released by the pop.
   assign space = c_CW'(DEPTH) - count_q + c_CW'(pop);

   // Acceptance is granted oldest-first, so the ALU push is the one dropped.
   assign ld_acc  = ld_v  && (space >= c_CW'(1));
   assign alu_acc = alu_v && (space >= (ld_acc ? c_CW'(2) : c_CW'(1)));

   // ALU lands behind the load when both are accepted.
   assign alu_idx = wr_ptr_q + c_PW'(ld_acc);

   always_comb begin
      rd_ptr_d = rd_ptr_q + c_PW'(pop);
      wr_ptr_d = wr_ptr_q + c_PW'(ld_acc) + c_PW'(alu_acc);
      count_d  = count_q + c_CW'(ld_acc) + c_CW'(alu_acc) - c_CW'(pop);
      ovf_d    = ovf_q | (ld_v & ~ld_acc) | (alu_v & ~alu_acc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_acc) begin
         addr_q[wr_ptr_q] <= ld_addr;
         data_q[wr_ptr_q] <= ld_data;
      end
      if (alu_acc) begin
         addr_q[alu_idx] <= alu_addr;
         data_q[alu_idx] <= alu_data;
      end
   end

   // Write port and flags depend only on registered state, so they hold
   // steady across the register file's clock-low latch phase.
   assign we       = (count_q != '0);
   assign empty    = (count_q == '0);
   assign full     = (count_q > c_CW'(DEPTH - 2));
   assign ovf      = ovf_q;
   assign dst_addr = we ? addr_q[rd_ptr_q] : '0;
   assign dst      = we ? data_q[rd_ptr_q] : '0;

`ifdef RF_WQ_FWD_EN
   logic [c_PW-1:0] lk_idx;

   // Walk from head (oldest) to tail; later matches overwrite earlier ones,
   // leaving the youngest pending value. The head is included because it
   // has not yet committed in the register file.
   always_comb begin
      hit0   = 1'b0;
      hit1   = 1'b0;
      fwd0   = '0;
      fwd1   = '0;
      lk_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         lk_idx = rd_ptr_q + c_PW'(i);
         if (c_CW'(i) < count_q) begin
            if ((rd0_addr != '0) && (addr_q[lk_idx] == rd0_addr)) begin
               hit0 = 1'b1;
               fwd0 = data_q[lk_idx];
            end
            if ((rd1_addr != '0) && (addr_q[lk_idx] == rd1_addr)) begin
               hit1 = 1'b1;
               fwd1 = data_q[lk_idx];
            end
         end
      end
   end
`else
   // Without forwarding, decode must wait for empty before reading.
   logic unused_rd;
   assign unused_rd = ^{rd0_addr, rd1_addr};
   assign hit0 = 1'b0;
   assign hit1 = 1'b0;
   assign fwd0 = '0;
   assign fwd1 = '0;
`endif

endmodule
`default_nettype wire
